// File: rtl/mux6x1_64bit.sv
// mux6x1_64bit: six-input, WIDTH-bit selector for the RISC-V datapath
// (ALU operand source, writeback source).
//
// Ports:
//   clk        - system clock, rising edge only
//   rst_n      - asynchronous active-low reset
//   A..F       - data inputs, selected by S = 0..5
//   S          - 3-bit select code
//   X          - selected data (all zeros for S = 6/7)
//   sel_err    - combinational flag, high while S is 6 or 7 (or unknown)
//   err_sticky - registered flag, set by any clock edge that sees sel_err
//   err_clr    - synchronous clear for err_sticky (wins over a set)
//
// Build option: define MUX6X1_OUTPUT_REG_EN to register X. This adds one cycle
// of latency and an async reset of X to zero. Otherwise X is purely
// combinational, has no clock dependence, and is unaffected by reset.
module mux6x1_64bit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [2:0]       S,
    input  logic             err_clr,
    output logic [WIDTH-1:0] X,
    output logic             sel_err,
    output logic             err_sticky
);

    logic [WIDTH-1:0] mux_d;

    // Illegal or unknown codes fall through to the default branch, so X never
    // carries X/Z from the select and the error flag is raised instead.
    always_comb begin
        mux_d   = '0;
        sel_err = 1'b0;
        case (S)
            3'd0:    mux_d = A;
            3'd1:    mux_d = B;
            3'd2:    mux_d = C;
            3'd3:    mux_d = D;
            3'd4:    mux_d = E;
            3'd5:    mux_d = F;
            default: begin
                mux_d   = '0;
                sel_err = 1'b1;
            end
        endcase
    end

`ifdef MUX6X1_OUTPUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) X <= '0;
        else        X <= mux_d;
    end
`else
    assign X = mux_d;
`endif

    // The clear is tested first so that it wins when a set arrives in the
    // same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_sticky <= 1'b0;
        else if (err_clr) err_sticky <= 1'b0;
        else if (sel_err) err_sticky <= 1'b1;
    end

endmodule

// File: tb/tb_mux6x1_64bit.sv
// Testbench for mux6x1_64bit: directed vectors. Stimulus pushes the expected
// {X, sel_err, err_sticky} into a queue and signals the monitor, which pops
// the entry and compares it with the live DUT outputs.
// Define MUX6X1_OUTPUT_REG_EN to check the registered-output build.
module tb_mux6x1_64bit;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A, B, C, D, E, F;
    logic [2:0]   S;
    logic         err_clr;
    logic [W-1:0] X;
    logic         sel_err;
    logic         err_sticky;

    typedef struct {
        string        name;
        logic [W-1:0] x;
        logic         se;
        logic         st;
    } exp_t;

    exp_t exp_q[$];
    event smp_ev;
    int   n_checks = 0;
    int   n_errors = 0;

    mux6x1_64bit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .E          (E),
        .F          (F),
        .S          (S),
        .err_clr    (err_clr),
        .X          (X),
        .sel_err    (sel_err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Monitor: one popped entry per sample event, each field a separate check.
    initial begin
        exp_t e;
        forever begin
            @(smp_ev);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL queue_underflow: sample with no expected entry");
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (X !== e.x) begin
                    n_errors++;
                    $display("FAIL %s.X: got %h expected %h", e.name, X, e.x);
                end
                n_checks++;
                if (sel_err !== e.se) begin
                    n_errors++;
                    $display("FAIL %s.sel_err: got %b expected %b", e.name, sel_err, e.se);
                end
                n_checks++;
                if (err_sticky !== e.st) begin
                    n_errors++;
                    $display("FAIL %s.err_sticky: got %b expected %b", e.name, err_sticky, e.st);
                end
            end
        end
    end

    task automatic push_exp(input string name, input logic [W-1:0] x,
                            input logic se, input logic st);
        exp_t e;
        e.name = name;
        e.x    = x;
        e.se   = se;
        e.st   = st;
        exp_q.push_back(e);
        -> smp_ev;
    endtask

    // Sample 1 ns after the current stimulus, before any clock edge.
    task automatic check_now(input string name, input logic [W-1:0] x,
                             input logic se, input logic st);
        #1;
        push_exp(name, x, se, st);
    endtask

    // Sample 1 ns after the next rising edge.
    task automatic check_edge(input string name, input logic [W-1:0] x,
                              input logic se, input logic st);
        @(posedge clk);
        #1;
        push_exp(name, x, se, st);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] vals [6];
        vals = '{64'd11, 64'd22, 64'd33, 64'd44, 64'd55, 64'd66};

        rst_n = 1'b0; err_clr = 1'b0; S = 3'd0;
        A = '0; B = '0; C = '0; D = '0; E = '0; F = '0;
        check_now("reset", 64'd0, 1'b0, 1'b0);

        @(negedge clk); rst_n = 1'b1;
        check_edge("release", 64'd0, 1'b0, 1'b0);

        @(negedge clk);
        A = 64'd11; B = 64'd22; C = 64'd33; D = 64'd44; E = 64'd55; F = 64'd66;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); S = 3'(i);
`ifndef MUX6X1_OUTPUT_REG_EN
            check_now($sformatf("sel%0d_comb", i), vals[i], 1'b0, 1'b0);
`endif
            check_edge($sformatf("sel%0d", i), vals[i], 1'b0, 1'b0);
            @(posedge clk);
        end

        // Illegal codes: X zeroed, flag raised, sticky set by the edge.
        @(negedge clk); S = 3'd6;
`ifndef MUX6X1_OUTPUT_REG_EN
        check_now("sel6_comb", 64'd0, 1'b1, 1'b0);
`endif
        check_edge("sel6", 64'd0, 1'b1, 1'b1);
        @(negedge clk); S = 3'd7;
        check_edge("sel7", 64'd0, 1'b1, 1'b1);
        @(negedge clk); S = 3'd2;
`ifndef MUX6X1_OUTPUT_REG_EN
        check_now("sel2_comb_sticky", 64'd33, 1'b0, 1'b1);
`endif
        check_edge("sel2_sticky_hold", 64'd33, 1'b0, 1'b1);

        // Clear beats a simultaneous set, then the set takes effect alone.
        @(negedge clk); S = 3'd7; err_clr = 1'b1;
        check_edge("clr_wins", 64'd0, 1'b1, 1'b0);
        @(negedge clk); err_clr = 1'b0;
        check_edge("set_after_clr", 64'd0, 1'b1, 1'b1);

        // Reset between edges clears sticky at once; comb X is untouched.
        @(negedge clk); S = 3'd2;
        #2 rst_n = 1'b0;
`ifdef MUX6X1_OUTPUT_REG_EN
        check_now("async_rst", 64'd0, 1'b0, 1'b0);
`else
        check_now("async_rst", 64'd33, 1'b0, 1'b0);
`endif
        @(negedge clk); S = 3'd7;
        check_edge("rst_held", 64'd0, 1'b1, 1'b0);
        @(negedge clk); S = 3'd3; rst_n = 1'b1;
        check_edge("rst_resume", 64'd44, 1'b0, 1'b0);

        // Unselected inputs must not disturb X.
        @(negedge clk); B = '1; C = 64'hDEAD_BEEF_0000_1234;
`ifndef MUX6X1_OUTPUT_REG_EN
        check_now("unsel_B_ones_comb", 64'd44, 1'b0, 1'b0);
`endif
        check_edge("unsel_B_ones", 64'd44, 1'b0, 1'b0);
        @(negedge clk); B = '0;
        check_edge("unsel_B_zero", 64'd44, 1'b0, 1'b0);

        // Full-width path on the selected input.
        @(negedge clk); D = 64'h8000_0000_0000_0001;
`ifndef MUX6X1_OUTPUT_REG_EN
        check_now("full_width_comb", 64'h8000_0000_0000_0001, 1'b0, 1'b0);
`endif
        check_edge("full_width", 64'h8000_0000_0000_0001, 1'b0, 1'b0);
        @(negedge clk); F = 64'hA5A5_5A5A_FFFF_0000; S = 3'd5;
        check_edge("full_width_F", 64'hA5A5_5A5A_FFFF_0000, 1'b0, 1'b0);

        // Output timing relative to the edge, and reset effect on X.
        @(negedge clk); S = 3'd4;
`ifdef MUX6X1_OUTPUT_REG_EN
        check_now("reg_prev_value", 64'hA5A5_5A5A_FFFF_0000, 1'b0, 1'b0);
`else
        check_now("sel4_immediate", 64'd55, 1'b0, 1'b0);
`endif
        check_edge("sel4_after_edge", 64'd55, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
`ifdef MUX6X1_OUTPUT_REG_EN
        check_now("reg_async_rst", 64'd0, 1'b0, 1'b0);
`else
        check_now("rst_keeps_X", 64'd55, 1'b0, 1'b0);
`endif
        @(negedge clk); rst_n = 1'b1;

        // Give the monitor a bounded window to drain the queue.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux6x1_64bit.md
Name: mux6x1_64bit

Overview:
- Six-input, 64-bit-wide selector used in the RISC-V datapath, e.g. for the ALU operand source or the writeback source.
- The data path is combinational by default.
- A clocked sideband flags illegal select codes.
- An optional build mode registers the output for timing closure.

Parameters:
- WIDTH, 64, data width of inputs A..F and output X.

Ports:
- clk  input  1  system clock; rising edge only.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  data input, selected when S=0.
- B  input  WIDTH  data input, selected when S=1.
- C  input  WIDTH  data input, selected when S=2.
- D  input  WIDTH  data input, selected when S=3.
- E  input  WIDTH  data input, selected when S=4.
- F  input  WIDTH  data input, selected when S=5.
- S  input  3  select code.
- X  output  WIDTH  selected data.
- sel_err  output  1  combinational flag: high while S is 6 or 7.
- err_sticky  output  1  registered flag: latches high after any clock edge that sees sel_err=1.
- err_clr  input  1  synchronous clear for err_sticky.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Select decoding:
  - S=0→A, 1→B, 2→C, 3→D, 4→E, 5→F.
  - S=6 or S=7 → X is all zeros and sel_err=1.
  - For S=0..5, sel_err=0.
- Default build (macro undefined):
  - X is purely combinational from A..F and S.
  - Zero-cycle latency; no clock dependence.
  - X is valid during reset.
- Any change on S or on the selected input propagates to X within the same delta or combinational settle.
- Changes on unselected inputs must not disturb X.
- Full-width copy: all WIDTH bits are passed unmodified. No sign handling, no truncation.
- err_sticky, updated on each rising clk edge:
  - if err_clr=1, it becomes 0;
  - else if sel_err=1, it becomes 1;
  - else it holds.
  - Clear has priority when err_clr and sel_err are both high in the same cycle.
- Reset:
  - rst_n=0 immediately forces err_sticky=0, independent of clk.
  - Releasing reset mid-operation resumes normal updates on the next rising edge.
  - Reset never affects X in the default build.
- No X/Z propagation from unknown select: S containing X/Z bits must produce X all-zero and sel_err=1.
  - In simulation this is implemented by the default branch of the case decode.

Optional Feature:
- Macro: MUX6X1_OUTPUT_REG_EN.
- Defined:
  - X is driven from a WIDTH-bit register loaded each rising clk edge with the decoded value. Latency is 1 cycle.
  - The register resets asynchronously to all zeros when rst_n=0.
  - sel_err stays combinational; err_sticky behaviour is unchanged.
- Undefined: X is combinational as described above, and no data register is inferred.

Test Plan:
- Initialise rst_n=0, A..F=0, S=0; then release reset → X=0, sel_err=0, err_sticky=0.
- A=11, B=22, C=33, D=44, E=55, F=66; step S=0..5 with 20 ns holds → X=11, 22, 33, 44, 55, 66 respectively, and sel_err=0 throughout.
- With the same inputs, S=6 then S=7 → X=0 and sel_err=1; after a clk edge, err_sticky=1. Then S=2 → X=33 and err_sticky remains 1.
- Set err_clr=1 together with S=7 for one edge → err_sticky=0 (clear wins). Next, err_clr=0 → err_sticky=1 after the edge. Then assert rst_n=0 between edges → err_sticky=0 immediately.
- S=3 with B toggled between 0 and 64'hFFFF_FFFF_FFFF_FFFF → X stays 44. Then D=64'h8000_0000_0000_0001 → X=64'h8000_0000_0000_0001, checking the full 64-bit path.
- With MUX6X1_OUTPUT_REG_EN defined: S=4 → X=55 only after the next rising clk edge, with the previous value before the edge. Asserting rst_n=0 → X=0 asynchronously.
